chan_arb_mux: RTL

//  Registered NUM_CH:1 channel multiplexer with built-in arbitration, generalising the 2:1 bus mux.

---
 rtl/chan_arb_mux_if.sv | 31 +++
 rtl/chan_arb_mux.sv | 108 ++++++++++
 2 files changed

// File: rtl/chan_arb_mux_if.sv
// Multi-master burst bus toward chan_arb_mux.
// Masters drive In*, the mux drives InReady and the registered Out* beat.
interface chan_arb_mux_if #(
  parameter int NUM_CH     = 4,
  parameter int DATA_WIDTH = 8,
  parameter int SEL_WIDTH  = 2
);
  logic [NUM_CH-1:0]            InValid;
  logic [NUM_CH*DATA_WIDTH-1:0] InData;
  logic [NUM_CH-1:0]            InLast;
  logic [NUM_CH-1:0]            InReady;
  logic                         OutValid;
  logic [DATA_WIDTH-1:0]        OutData;
  logic                         OutLast;
  logic [SEL_WIDTH-1:0]         OutChan;
  logic                         OutReady;
  logic [NUM_CH-1:0]            Grant;
  logic                         Busy;

  modport master (
    output InValid, InData, InLast, OutReady,
    input  InReady, OutValid, OutData, OutLast,
    input  OutChan, Grant, Busy
  );

  modport slave (
    input  InValid, InData, InLast, OutReady,
    output InReady, OutValid, OutData, OutLast,
    output OutChan, Grant, Busy
  );
endinterface

// File: rtl/chan_arb_mux.sv
// NUM_CH:1 burst arbiter/mux with one registered output beat.
// Grant is held for a whole burst, cut after BURST_MAX beats.
module chan_arb_mux #(
  parameter int NUM_CH     = 4,
  parameter int DATA_WIDTH = 8,
  parameter int SEL_WIDTH  = 2,
  parameter int PRIO_MODE  = 0,
  parameter int BURST_MAX  = 8
) (
  input logic            Clk,
  input logic            Reset_n,
  chan_arb_mux_if.slave  bus
);
  localparam int CW = $clog2(BURST_MAX + 1);

  typedef enum logic {IDLE, XFER} state_t;

  state_t                state;
  logic [NUM_CH-1:0]     grant;
  logic [SEL_WIDTH-1:0]  gidx;
  logic [SEL_WIDTH-1:0]  ptr;
  logic [SEL_WIDTH-1:0]  win;
  logic [CW-1:0]         cnt;
  logic                  ov;
  logic                  ol;
  logic [DATA_WIDTH-1:0] od;
  logic [SEL_WIDTH-1:0]  oc;
  logic                  open;
  logic                  accept;
  logic                  cut;
  logic                  found;
  int                    idx;

  // RR searches upward from ptr with wrap; fixed mode from index 0
  always_comb begin
    win   = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (PRIO_MODE != 0) idx = k;
      else idx = (int'(ptr) + k) % NUM_CH;
      if (!found && bus.InValid[idx]) begin
        found = 1'b1;
        win   = SEL_WIDTH'(idx);
      end
    end
  end

  assign open   = ~ov | bus.OutReady;
  assign accept = (state == XFER) & bus.InValid[gidx] & open;
  assign cut    = bus.InLast[gidx]
                | (cnt == CW'(BURST_MAX - 1));

  assign bus.InReady  = (state == XFER && open) ? grant : '0;
  assign bus.OutValid = ov;
  assign bus.OutData  = od;
  assign bus.OutLast  = ol;
  assign bus.OutChan  = oc;
  assign bus.Grant    = grant;
  assign bus.Busy     = (state == XFER);

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state <= IDLE;
      grant <= '0;
      gidx  <= '0;
      ptr   <= '0;
      cnt   <= '0;
      ov    <= 1'b0;
      ol    <= 1'b0;
      od    <= '0;
      oc    <= '0;
    end else begin
      // a fresh accept overwrites a draining beat, so no bubble
      if (accept) begin
        ov <= 1'b1;
        od <= bus.InData[gidx*DATA_WIDTH +: DATA_WIDTH];
        ol <= cut;
        oc <= gidx;
      end else if (ov && bus.OutReady) begin
        ov <= 1'b0;
      end

      unique case (state)
        IDLE: begin
          if (|bus.InValid) begin
            state <= XFER;
            grant <= NUM_CH'(1) << win;
            gidx  <= win;
            cnt   <= '0;
          end
        end
        XFER: begin
          if (accept) begin
            cnt <= cnt + 1'b1;
            if (cut) begin
              state <= IDLE;
              grant <= '0;
              ptr   <= (int'(gidx) == NUM_CH - 1) ?
                       '0 : gidx + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
